nixie_scan_driver: RTL and testbench

//  Downstream display stage for all mode controllers (free, autoplay, study).
//  - Takes a packed 8-character, 6-bit-per-char text word.
//  - Time-multiplexes it onto the two 4-digit seven-segment groups.
//  - Frame-coherent input snapshot, anti-ghosting blanking, per-digit blink.

---
 rtl/nixie_scan_if.sv | 28 ++
 rtl/nixie_scan_driver.sv | 194 +++++++++++++++++++
 tb/tb_nixie_scan_driver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nixie_scan_if.sv
// Display-side bundle of the nixie scan driver: text/blink-mask in from the mode
// controllers, multiplexed digit enables and segment groups out to the tubes.
interface nixie_scan_if;
    logic [47:0] in;
    logic [7:0]  blink_mask;
    logic [7:0]  sel;
    logic [7:0]  tub1;
    logic [7:0]  tub2;
    logic        frame_start;

    modport master (
        output in,
        output blink_mask,
        input  sel,
        input  tub1,
        input  tub2,
        input  frame_start
    );

    modport slave (
        input  in,
        input  blink_mask,
        output sel,
        output tub1,
        output tub2,
        output frame_start
    );
endinterface

// File: rtl/nixie_scan_driver.sv
// Scans a packed 8-character text word onto two 4-digit seven-segment groups,
// with a once-per-frame input snapshot, anti-ghost blanking and per-digit blink.
module nixie_scan_driver #(
    parameter int unsigned SCAN_DIV     = 25000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic        sys_clk,
    input  logic        sys_rest,
    nixie_scan_if.slave disp
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]   BLANK_END  = DIV_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [47:0]        TEXT_BLANK = {48{1'b1}};

    // Segment order is {a,b,c,d,e,f,g,dp}; dp is never lit.
    function automatic logic [7:0] glyph(input logic [5:0] code);
        logic [7:0] seg;
        case (code)
            6'd0:    seg = 8'hEE;  // A
            6'd1:    seg = 8'h3E;  // b
            6'd2:    seg = 8'h9C;  // C
            6'd3:    seg = 8'h7A;  // d
            6'd4:    seg = 8'h9E;  // E
            6'd5:    seg = 8'h8E;  // F
            6'd6:    seg = 8'hBC;  // G
            6'd7:    seg = 8'h6E;  // H
            6'd8:    seg = 8'h0C;  // I
            6'd9:    seg = 8'h78;  // J
            6'd10:   seg = 8'hAE;  // K
            6'd11:   seg = 8'h1C;  // L
            6'd12:   seg = 8'hEC;  // M
            6'd13:   seg = 8'h2A;  // n
            6'd14:   seg = 8'hFC;  // O
            6'd15:   seg = 8'hCE;  // P
            6'd16:   seg = 8'hE6;  // q
            6'd17:   seg = 8'h0A;  // r
            6'd18:   seg = 8'hB6;  // S
            6'd19:   seg = 8'h1E;  // t
            6'd20:   seg = 8'h7C;  // U
            6'd21:   seg = 8'h38;  // v
            6'd22:   seg = 8'h7E;  // W
            6'd23:   seg = 8'h6E;  // X
            6'd24:   seg = 8'h76;  // Y
            6'd25:   seg = 8'hDA;  // Z
            6'd44:   seg = 8'h7C;  // U
            6'd48:   seg = 8'h76;  // Y
            6'd50:   seg = 8'hFC;
            6'd51:   seg = 8'h60;
            6'd52:   seg = 8'hDA;
            6'd53:   seg = 8'hF2;
            6'd54:   seg = 8'h66;
            6'd55:   seg = 8'hB6;
            6'd56:   seg = 8'hBE;
            6'd57:   seg = 8'hE0;
            6'd58:   seg = 8'hFE;
            6'd59:   seg = 8'hF6;
            6'd60:   seg = 8'h02;  // middle octave
            6'd61:   seg = 8'h80;  // high octave
            6'd62:   seg = 8'h10;  // low octave
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    // Character k (k=0 leftmost) lives in the top-down 6-bit field k.
    function automatic logic [5:0] char_at(input logic [47:0] text, input logic [2:0] k);
        logic [5:0] c;
        case (k)
            3'd0:    c = text[47:42];
            3'd1:    c = text[41:36];
            3'd2:    c = text[35:30];
            3'd3:    c = text[29:24];
            3'd4:    c = text[23:18];
            3'd5:    c = text[17:12];
            3'd6:    c = text[11:6];
            default: c = text[5:0];
        endcase
        return c;
    endfunction

    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic [1:0]         phase_q,     phase_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q,  blink_on_d;
    logic [47:0]        text_q,      text_d;
    logic [7:0]         mask_q,      mask_d;
    logic               shown_q,     shown_d;
    logic [7:0]         sel_q,       sel_d;
    logic [7:0]         tub1_q,      tub1_d;
    logic [7:0]         tub2_q,      tub2_d;
    logic               frame_start_q, frame_start_d;

    logic       phase_end;
    logic       snap;
    logic [7:0] scan_pat;
    logic [5:0] left_char;
    logic [5:0] right_char;

    assign phase_end = (div_cnt_q == DIV_LAST);
    assign snap      = phase_end && (phase_q == 2'd3);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        div_cnt_d     = div_cnt_q + DIV_W'(1);
        phase_d       = phase_q;
        blink_cnt_d   = blink_cnt_q;
        blink_on_d    = blink_on_q;
        text_d        = text_q;
        mask_d        = mask_q;
        shown_d       = shown_q;
        frame_start_d = snap;

        if (phase_end) begin
            div_cnt_d = '0;
            phase_d   = phase_q + 2'd1;
        end

        if (snap) begin
            text_d  = disp.in;
            mask_d  = disp.blink_mask;
            shown_d = 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Digit enables stay off until the first snapshot lands, so the tubes are
    // dark for the whole first frame after reset.
    always_comb begin
        scan_pat   = 8'h88 >> phase_q;
        left_char  = char_at(text_q, {1'b0, phase_q});
        right_char = char_at(text_q, {1'b1, phase_q});

        sel_d  = (shown_q && (div_cnt_q >= BLANK_END)) ? scan_pat : 8'h00;
        tub1_d = glyph(left_char);
        tub2_d = glyph(right_char);

        if (blink_on_q && |(mask_q[7:4] & scan_pat[7:4])) begin
            tub1_d = 8'h00;
        end
        if (blink_on_q && |(mask_q[3:0] & scan_pat[3:0])) begin
            tub2_d = 8'h00;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rest) begin
        if (!sys_rest) begin
            div_cnt_q     <= '0;
            phase_q       <= 2'd0;
            blink_cnt_q   <= '0;
            blink_on_q    <= 1'b0;
            // NOTE: the snapshot registers are reset on purpose: all-ones codes
            // are blank glyphs, keeping the display dark until real text arrives.
            text_q        <= TEXT_BLANK;
            mask_q        <= 8'h00;
            shown_q       <= 1'b0;
            sel_q         <= 8'h00;
            tub1_q        <= 8'h00;
            tub2_q        <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from the
            // same pre-edge values, independent of statement order.
            div_cnt_q     <= div_cnt_d;
            phase_q       <= phase_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_on_q    <= blink_on_d;
            text_q        <= text_d;
            mask_q        <= mask_d;
            shown_q       <= shown_d;
            sel_q         <= sel_d;
            tub1_q        <= tub1_d;
            tub2_q        <= tub2_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign disp.sel         = sel_q;
    assign disp.tub1        = tub1_q;
    assign disp.tub2        = tub2_q;
    assign disp.frame_start = frame_start_q;

endmodule

// File: tb/tb_nixie_scan_driver.sv
// Scoreboard bench for nixie_scan_driver: stimulus queues per-cycle expected
// outputs tagged by cycle number; a monitor pops and compares them.
module tb_nixie_scan_driver;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYC    = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 4 * SCAN_DIV;
    localparam int RST_TAG      = -1;

    // Texts (char 0 first) and the segment patterns expected per phase 0..3.
    localparam logic [47:0] PLAY1 = {6'd15, 6'd11, 6'd0, 6'd24, 6'd51, 6'd63, 6'd63, 6'd63};
    localparam logic [47:0] DIGS  = {6'd50, 6'd51, 6'd52, 6'd53, 6'd54, 6'd55, 6'd56, 6'd57};
    localparam logic [31:0] PLAY_T1  = 32'hCE1C_EE76;
    localparam logic [31:0] PLAY_T2  = 32'h6000_0000;
    localparam logic [31:0] BLINK_T1 = 32'h001C_EE76;
    localparam logic [31:0] DIGS_T1  = 32'hFC60_DAF2;
    localparam logic [31:0] DIGS_T2  = 32'h66B6_BEE0;
    localparam logic [31:0] MIX_T1   = 32'h7AB6_1E7C;

    typedef struct {
        int         cyc;
        logic [7:0] sel;
        logic [7:0] tub1;
        logic [7:0] tub2;
        logic       fs;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rest;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   stim_cyc = 0;

    nixie_scan_if bus ();

    nixie_scan_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rest(sys_rest),
        .disp    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [47:0] mix_text(input logic [5:0] c4);
        return {6'd3, 6'd18, 6'd19, 6'd44, c4, 6'd48, 6'd59, 6'd63};
    endfunction

    task automatic check(input string name, input int cyc, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%02h want=%02h", name, cyc, act, exp);
        end
    endtask

    task automatic push_zero(input int tag);
        exp_t e;
        e.cyc  = tag;
        e.sel  = 8'h00;
        e.tub1 = 8'h00;
        e.tub2 = 8'h00;
        e.fs   = 1'b0;
        sb_q.push_back(e);
    endtask

    // Frame k occupies cycles FRAME*k+1 .. FRAME*k+FRAME after reset release.
    task automatic push_frame(input int k, input logic [31:0] t1, input logic [31:0] t2,
                              input int last_cyc);
        for (int j = 0; j < FRAME; j++) begin
            exp_t e;
            int   p;
            int   d;
            p      = j / SCAN_DIV;
            d      = j % SCAN_DIV;
            e.cyc  = FRAME * k + j + 1;
            e.sel  = (k == 0 || d < BLANK_CYC) ? 8'h00 : 8'(8'h88 >> p);
            e.tub1 = t1[31 - 8 * p -: 8];
            e.tub2 = t2[31 - 8 * p -: 8];
            e.fs   = (j == FRAME - 1);
            if (e.cyc <= last_cyc) sb_q.push_back(e);
        end
    endtask

    task automatic drain(input int tag);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q[0];
            if (e.cyc == tag) begin
                e = sb_q.pop_front();
                check("sel", tag, bus.sel, e.sel);
                check("tub1", tag, bus.tub1, e.tub1);
                check("tub2", tag, bus.tub2, e.tub2);
                check("frame_start", tag, {7'b0, bus.frame_start}, {7'b0, e.fs});
            end else if (tag >= 0 && e.cyc >= 0 && e.cyc < tag) begin
                e = sb_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missed cyc=%0d got=none want=entry", e.cyc);
            end else begin
                break;
            end
        end
    endtask

    initial begin : monitor
        int cyc;
        cyc = 0;
        forever begin
            @(negedge sys_clk or negedge sys_rest);
            if (sys_rest !== 1'b1) begin
                #1;
                drain(RST_TAG);
                cyc = 0;
            end else begin
                drain(cyc);
                cyc++;
            end
        end
    end

    task automatic release_reset();
        @(posedge sys_clk);
        #2;
        sys_rest = 1'b1;
        stim_cyc = 0;
    endtask

    task automatic run_to(input int t);
        while (stim_cyc < t) begin
            @(posedge sys_clk);
            stim_cyc++;
        end
        #1;
    endtask

    initial begin : stimulus
        bus.in         = PLAY1;
        bus.blink_mask = 8'h00;
        push_zero(RST_TAG);
        sys_rest = 1'b0;
        repeat (3) @(posedge sys_clk);

        // Blank first frame, then PLAY1 with blanking slots per phase.
        release_reset();
        push_zero(0);
        push_frame(0, 32'h0, 32'h0, 1 << 30);
        push_frame(1, PLAY_T1, PLAY_T2, 1 << 30);
        push_frame(2, PLAY_T1, PLAY_T2, 1 << 30);

        // Mid-frame text change only shows after the next snapshot.
        run_to(74);
        bus.in = DIGS;
        push_frame(3, DIGS_T1, DIGS_T2, 1 << 30);

        // Octave markers and an unmapped code on char 4.
        run_to(100);
        bus.in = mix_text(6'd60);
        push_frame(4, MIX_T1, 32'h0276_F600, 1 << 30);
        run_to(132);
        bus.in = mix_text(6'd61);
        push_frame(5, MIX_T1, 32'h8076_F600, 1 << 30);
        run_to(164);
        bus.in = mix_text(6'd62);
        push_frame(6, MIX_T1, 32'h1076_F600, 1 << 30);
        run_to(196);
        bus.in = mix_text(6'd40);
        push_frame(7, MIX_T1, 32'h0076_F600, 1 << 30);

        // Blink on char 0: blink_on toggles at every second snapshot.
        run_to(228);
        bus.in         = PLAY1;
        bus.blink_mask = 8'h80;
        push_frame(8, PLAY_T1, PLAY_T2, 1 << 30);
        push_frame(9, PLAY_T1, PLAY_T2, 1 << 30);
        push_frame(10, BLINK_T1, PLAY_T2, 1 << 30);
        push_frame(11, BLINK_T1, PLAY_T2, 1 << 30);
        push_frame(12, PLAY_T1, PLAY_T2, 1 << 30);
        push_frame(13, PLAY_T1, PLAY_T2, 435);

        // Reset in phase 2 of frame 13, then the start-up timing again.
        run_to(436);
        push_zero(RST_TAG);
        sys_rest       = 1'b0;
        bus.blink_mask = 8'h00;
        repeat (2) @(posedge sys_clk);
        release_reset();
        push_zero(0);
        push_frame(0, 32'h0, 32'h0, 1 << 30);
        push_frame(1, PLAY_T1, PLAY_T2, 1 << 30);
        push_frame(2, PLAY_T1, PLAY_T2, 1 << 30);

        run_to(100);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover got=%0d want=0 entries", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

endmodule
